// File: rtl/demux_fifo4.sv
// demux_fifo4: routes the class-mux word stream into four per-class FIFOs.
// Class ID is data_in[11:10]; an all-zero word is idle. Each FIFO has its own
// pop, registered read data (1-cycle latency), valid pulse and status flags.
// Optional feature: define DEMUX_DROP_CNT_EN to add the 8-bit saturating
// drop_cnt output counting words dropped on a full FIFO.
module demux_fifo4 #(
    parameter int DEPTH = 4,
    parameter int AF_TH = 3
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic [11:0] data_in,
    input  logic [3:0]  pop,
    output logic [11:0] data_out0,
    output logic [11:0] data_out1,
    output logic [11:0] data_out2,
    output logic [11:0] data_out3,
    output logic [3:0]  valid_out,
    output logic [3:0]  empty,
    output logic [3:0]  full,
    output logic [3:0]  almost_full,
    output logic        overflow,
    output logic        underflow
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    logic [11:0]   mem_q      [4][DEPTH];
    logic [11:0]   mem_d      [4][DEPTH];
    logic [PW-1:0] wr_ptr_q   [4];
    logic [PW-1:0] wr_ptr_d   [4];
    logic [PW-1:0] rd_ptr_q   [4];
    logic [PW-1:0] rd_ptr_d   [4];
    logic [CW-1:0] cnt_q      [4];
    logic [CW-1:0] cnt_d      [4];
    logic [11:0]   data_out_q [4];
    logic [11:0]   data_out_d [4];
    logic [3:0]    valid_out_q;
    logic [3:0]    valid_out_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;

    logic          push_v_s;
    logic [3:0]    push_hit_s;
    logic [3:0]    push_ok_s;
    logic [3:0]    pop_ok_s;
    logic [3:0]    drop_s;
    logic [3:0]    pop_empty_s;

    // Status flags decoded straight from the occupancy counts
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            empty[n]       = (cnt_q[n] == ZERO_C);
            full[n]        = (cnt_q[n] == DEPTH_C);
            almost_full[n] = (cnt_q[n] >= AF_C);
        end
    end

    // Decode push target and qualify pushes/pops against the flags
    always_comb begin
        push_v_s = (data_in != 12'h000);
        for (int n = 0; n < 4; n++) begin
            push_hit_s[n]  = push_v_s && (data_in[11:10] == 2'(n));
            pop_ok_s[n]    = pop[n] && !empty[n];
            // A pop on a full FIFO frees the slot the incoming word takes
            push_ok_s[n]   = push_hit_s[n] && (!full[n] || pop[n]);
            drop_s[n]      = push_hit_s[n] && full[n] && !pop[n];
            pop_empty_s[n] = pop[n] && empty[n];
        end
    end

    // Next-state for storage, pointers, counts and registered read port
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            if (push_ok_s[n]) begin
                mem_d[n][wr_ptr_q[n]] = data_in;
                wr_ptr_d[n]           = wr_ptr_q[n] + PW'(1);
            end else begin
                wr_ptr_d[n] = wr_ptr_q[n];
            end
            if (pop_ok_s[n]) begin
                data_out_d[n]  = mem_q[n][rd_ptr_q[n]];
                rd_ptr_d[n]    = rd_ptr_q[n] + PW'(1);
                valid_out_d[n] = 1'b1;
            end else begin
                data_out_d[n]  = data_out_q[n];
                rd_ptr_d[n]    = rd_ptr_q[n];
                valid_out_d[n] = 1'b0;
            end
            case ({push_ok_s[n], pop_ok_s[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CW'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - CW'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
        overflow_d  = overflow_q  | (|drop_s);
        underflow_d = underflow_q | (|pop_empty_s);
    end

    // Storage array; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n]   <= '0;
                rd_ptr_q[n]   <= '0;
                cnt_q[n]      <= '0;
                data_out_q[n] <= 12'h000;
            end
            valid_out_q <= 4'b0000;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    // Saturating count of words dropped on a full FIFO
    always_comb begin
        if ((|drop_s) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'h01;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign data_out0 = data_out_q[0];
    assign data_out1 = data_out_q[1];
    assign data_out2 = data_out_q[2];
    assign data_out3 = data_out_q[3];
    assign valid_out = valid_out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_demux_fifo4.sv
// Directed self-checking bench for demux_fifo4 (DEPTH=4, AF_TH=3).
module tb_demux_fifo4;

    logic        clk;
    logic        reset_L;
    logic [11:0] data_in;
    logic [3:0]  pop;
    logic [11:0] data_out0;
    logic [11:0] data_out1;
    logic [11:0] data_out2;
    logic [11:0] data_out3;
    logic [3:0]  valid_out;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  almost_full;
    logic        overflow;
    logic        underflow;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    demux_fifo4 #(.DEPTH(4), .AF_TH(3)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .pop         (pop),
        .data_out0   (data_out0),
        .data_out1   (data_out1),
        .data_out2   (data_out2),
        .data_out3   (data_out3),
        .valid_out   (valid_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic step(input logic [11:0] d, input logic [3:0] p);
        data_in = d;
        pop     = p;
        @(posedge clk);
        #1;
        data_in = 12'h000;
        pop     = 4'b0000;
    endtask

    initial begin
        logic [11:0] exp_w;
        reset_L = 1'b0;
        data_in = 12'h000;
        pop     = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // Reset state
        check("rst_empty", 32'(empty), 32'h0000_000F);
        check("rst_full", 32'(full), 32'h0);
        check("rst_af", 32'(almost_full), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_udf", 32'(underflow), 32'h0);
        check("rst_dout", {8'h00, data_out0 | data_out1 | data_out2 | data_out3}, 32'h0);

        // Routing by class ID
        step(12'h005, 4'b0000);
        step(12'h40A, 4'b0000);
        step(12'h80F, 4'b0000);
        step(12'hC01, 4'b0000);
        check("route_empty", 32'(empty), 32'h0);
        step(12'h000, 4'b1111);
        check("route_valid", 32'(valid_out), 32'h0000_000F);
        check("route_d0", 32'(data_out0), 32'h005);
        check("route_d1", 32'(data_out1), 32'h40A);
        check("route_d2", 32'(data_out2), 32'h80F);
        check("route_d3", 32'(data_out3), 32'hC01);
        step(12'h000, 4'b0000);
        check("route_valid_drop", 32'(valid_out), 32'h0);
        check("route_hold_d2", 32'(data_out2), 32'h80F);
        check("route_empty_after", 32'(empty), 32'h0000_000F);

        // Order, flags and pointer wrap on class 1
        step(12'h401, 4'b0000);
        step(12'h402, 4'b0000);
        check("af1_at2", 32'(almost_full[1]), 32'h0);
        step(12'h403, 4'b0000);
        check("af1_at3", 32'(almost_full[1]), 32'h1);
        check("full1_at3", 32'(full[1]), 32'h0);
        step(12'h404, 4'b0000);
        check("full1_at4", 32'(full[1]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(12'h000, 4'b0010);
            exp_w = 12'h401 + 12'(i);
            check("order_d1", 32'(data_out1), 32'(exp_w));
            check("order_v1", 32'(valid_out), 32'h2);
        end
        check("order_empty1", 32'(empty[1]), 32'h1);
        step(12'h405, 4'b0000);
        step(12'h406, 4'b0000);
        step(12'h000, 4'b0010);
        check("wrap_d1a", 32'(data_out1), 32'h405);
        step(12'h000, 4'b0010);
        check("wrap_d1b", 32'(data_out1), 32'h406);

        // Overflow on class 3: drop without pop, accept with pop
        step(12'hC01, 4'b0000);
        step(12'hC02, 4'b0000);
        step(12'hC03, 4'b0000);
        step(12'hC04, 4'b0000);
        check("ovf_pre", 32'(overflow), 32'h0);
        step(12'hCAA, 4'b0000);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_full3", 32'(full[3]), 32'h1);
`ifdef DEMUX_DROP_CNT_EN
        check("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
        for (int i = 0; i < 4; i++) begin
            step(12'h000, 4'b1000);
            exp_w = 12'hC01 + 12'(i);
            check("ovf_drain_d3", 32'(data_out3), 32'(exp_w));
        end
        check("ovf_empty3", 32'(empty[3]), 32'h1);
        step(12'hC11, 4'b0000);
        step(12'hC12, 4'b0000);
        step(12'hC13, 4'b0000);
        step(12'hC14, 4'b0000);
        step(12'hCAA, 4'b1000);
        check("full_pp_d3", 32'(data_out3), 32'hC11);
        check("full_pp_full3", 32'(full[3]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(12'h000, 4'b1000);
            exp_w = (i == 3) ? 12'hCAA : 12'hC12 + 12'(i);
            check("full_pp_drain", 32'(data_out3), 32'(exp_w));
        end
        check("full_pp_empty3", 32'(empty[3]), 32'h1);

        // Underflow on class 0
        check("udf_pre", 32'(underflow), 32'h0);
        step(12'h000, 4'b0001);
        check("udf_valid0", 32'(valid_out[0]), 32'h0);
        check("udf_set", 32'(underflow), 32'h1);
        check("udf_empty0", 32'(empty[0]), 32'h1);
        step(12'h011, 4'b0000);
        step(12'h000, 4'b0001);
        check("udf_then_d0", 32'(data_out0), 32'h011);
        check("udf_then_v0", 32'(valid_out[0]), 32'h1);
        step(12'h022, 4'b0001);
        check("pe_push_v0", 32'(valid_out[0]), 32'h0);
        check("pe_push_empty0", 32'(empty[0]), 32'h0);
        step(12'h000, 4'b0001);
        check("pe_push_d0", 32'(data_out0), 32'h022);

        // Idle: FIFO 2 holds 3 words, nothing may change
        step(12'h801, 4'b0000);
        step(12'h802, 4'b0000);
        step(12'h803, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(12'h000, 4'b0000);
            check("idle_flags", {empty, full, almost_full, valid_out, 14'h0, overflow, underflow},
                  {4'b1011, 4'b0000, 4'b0100, 4'b0000, 14'h0, 1'b1, 1'b1});
        end

        // Reset mid-stream with FIFO 2 holding 3 words
        reset_L = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 32'h0000_000F);
        @(posedge clk);
        #1;
        check("mrst_empty", 32'(empty), 32'h0000_000F);
        check("mrst_valid", 32'(valid_out), 32'h0);
        check("mrst_dout", {8'h00, data_out0 | data_out1 | data_out2 | data_out3}, 32'h0);
        check("mrst_ovf", 32'(overflow), 32'h0);
        check("mrst_udf", 32'(underflow), 32'h0);
        check("mrst_af", 32'(almost_full), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        check("mrst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        reset_L = 1'b1;
        step(12'h805, 4'b0000);
        step(12'h000, 4'b0100);
        check("post_rst_d2", 32'(data_out2), 32'h805);
        check("post_rst_empty2", 32'(empty[2]), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_fifo4.md
Name: demux_fifo4

Overview:
- Stage directly downstream of the 4:1 class mux.
- Takes the mux's 12-bit word stream and routes each word by class ID bits [11:10] into one of four per-class FIFOs.
- Each FIFO has an independent pop interface and status flags; an all-zero input word means idle.
- Feeds the four per-class consumers that follow.

Parameters:
- DEPTH, 4, entries per class FIFO; power of 2, ≥2.
- AF_TH, 3, almost-full threshold in entries; 1 ≤ AF_TH ≤ DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  12  word from mux; [11:10] = class ID, [9:0] = payload; 12'h000 = idle.
- pop  input  4  pop[n] requests a read of FIFO n.
- data_out0, data_out1, data_out2, data_out3  output  12 each  registered read data per class.
- valid_out  output  4  valid_out[n] high for exactly one cycle when data_outN carries a popped word.
- empty  output  4  FIFO n holds 0 entries.
- full  output  4  FIFO n holds DEPTH entries.
- almost_full  output  4  FIFO n occupancy ≥ AF_TH.
- overflow  output  1  sticky; set when a word was dropped.
- underflow  output  1  sticky; set when a pop hit an empty FIFO.
- drop_cnt  output  8  present only with DEMUX_DROP_CNT_EN.

Behaviour:
- Reset (reset_L = 0, asynchronous assert, synchronous deassert by the consumer):
  - All pointers and occupancy counts = 0; storage contents don't-care.
  - data_out0-3 = 0, valid_out = 0, empty = 4'b1111, full = 0, almost_full = 0, overflow = 0, underflow = 0, drop_cnt = 0.
  - Reset mid-operation discards all queued words immediately.
- Push:
  - Each cycle with data_in != 0, target n = data_in[11:10].
  - The word, all 12 bits including ID, is written to FIFO n at wr_ptr[n]; wr_ptr[n] increments modulo DEPTH.
  - At most one push per cycle system-wide.
- Full on push:
  - If full[n] and pop[n] = 0 in the same cycle, the word is dropped and overflow sets.
  - If full[n] and pop[n] = 1 in the same cycle, the push is accepted; occupancy stays DEPTH.
- Pop:
  - pop[n] with empty[n] = 0: the entry at rd_ptr[n] is registered into data_outN, valid_out[n] = 1 the next cycle, and rd_ptr[n] increments modulo DEPTH.
  - Read latency is 1 cycle.
  - data_outN holds its last value when not popping; valid_out[n] returns to 0.
- Pop on empty:
  - pop[n] with empty[n] = 1 is ignored; underflow sets and valid_out[n] stays 0.
  - A push to an empty FIFO n plus pop[n] in the same cycle counts as pop-on-empty: the pop is ignored, the push is accepted, and underflow sets.
- Parallelism: pops on different FIFOs are independent and may all occur in the same cycle as one push.
- Occupancy: count[n] has log2(DEPTH)+1 bits.
  - Push only: +1. Pop only: -1. Both: unchanged.
- Flags:
  - empty, full and almost_full are combinational from count[n].
  - They reflect state after the last clock edge and never go negative or above DEPTH.
- Pointer wrap: pointers wrap silently from DEPTH-1 to 0; ordering within a class is strict FIFO.
- Sticky errors: overflow and underflow clear only on reset.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - drop_cnt port exists, an 8-bit counter of dropped words.
  - Increments by 1 per dropped push and saturates at 8'hFF.
  - Cleared only by reset.
  - overflow still behaves as specified.
- Undefined:
  - No drop_cnt port and no counter logic.
  - overflow is the only drop indication.

Test Plan:
- Reset check: assert reset_L = 0 mid-stream with FIFO 2 holding 3 words -> next cycle empty = 4'b1111, valid_out = 0, all data_outN = 0, overflow = 0.
- Routing: push 12'h005, 12'h40A, 12'h80F, 12'hC01, then pop = 4'b1111 -> one cycle later valid_out = 4'b1111; data_out0..3 = 005, 40A, 80F, C01.
- Order and wrap: push 6 words 12'h401..12'h406 to class 1, popping after each 4 -> pops return 401..406 in order; full[1] asserts after the 4th unpopped push; almost_full[1] asserts at 3 entries.
- Overflow: fill FIFO 3 (DEPTH = 4), push 12'hCAA with pop[3] = 0 -> word dropped, overflow = 1, drop_cnt = 1 (macro on); repeat with pop[3] = 1 -> accepted, count stays 4.
- Underflow: pop = 4'b0001 with FIFO 0 empty -> valid_out[0] = 0, underflow = 1, pointers unchanged; then push 12'h011 and pop next cycle -> data_out0 = 12'h011.
- Idle: hold data_in = 12'h000 for 10 cycles -> no occupancy change, no flags change.
